// File: rtl/leb128_encoder.sv
// Streaming LEB128 encoder: accepts a 32/64-bit operand and emits its unsigned
// or signed LEB128 byte sequence, one byte per out_valid/out_ready handshake.
module leb128_encoder #(
    parameter int WIDTH    = 64,
    parameter int CNT_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_value,
    input  logic                in_signed,
    input  logic                in_is64,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_byte,
    output logic                out_last,
    output logic [CNT_BITS-1:0] out_index
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    val_q, val_d;
    logic                signed_q, signed_d;
    logic [CNT_BITS-1:0] idx_q, idx_d;

    logic [WIDTH-1:0]    rest;
    logic                done;

    // Remaining payload after the current 7 bits leave; sLEB shifts arithmetically.
    always_comb begin
        rest = signed_q ? {{7{val_q[WIDTH-1]}}, val_q[WIDTH-1:7]}
                        : {7'b0, val_q[WIDTH-1:7]};
        if (signed_q)
            done = ((rest == '0) && !val_q[6]) || ((rest == '1) && val_q[6]);
        else
            done = (rest == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            val_q    <= '0;
            signed_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            val_q    <= val_d;
            signed_q <= signed_d;
            idx_q    <= idx_d;
        end
    end

    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        val_d    = val_q;
        signed_d = signed_q;
        idx_d    = idx_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = EMIT;
                    signed_d = in_signed;
                    idx_d    = '0;
                    if (in_is64)
                        val_d = in_value;
                    else if (in_signed)
                        val_d = {{(WIDTH-32){in_value[31]}}, in_value[31:0]};
                    else
                        val_d = {{(WIDTH-32){1'b0}}, in_value[31:0]};
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (done) begin
                        state_d = IDLE;
                    end else begin
                        val_d = rest;
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == EMIT);
        out_byte  = 8'h00;
        out_last  = 1'b0;
        out_index = '0;
        if (state_q == EMIT) begin
            out_byte  = {~done, val_q[6:0]};
            out_last  = done;
            out_index = idx_q;
        end
    end

endmodule

// File: tb/tb_leb128_encoder.sv
// Self-checking bench for leb128_encoder: directed vectors with literal expected
// bytes, then randomized operands scored against an arithmetic LEB128 model.
module tb_leb128_encoder;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_value;
    logic        in_signed;
    logic        in_is64;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
    logic [3:0]  out_index;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    leb128_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .in_signed (in_signed),
        .in_is64   (in_is64),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last),
        .out_index (out_index)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: repeatedly peel off the low 7 bits with plain division.
    function automatic byte_q_t model(input logic [63:0] v, input bit sg, input bit w64);
        byte_q_t     q;
        logic [63:0] u;
        longint      s;
        longint      b;
        bit          fin;
        if (!w64) v = sg ? {{32{v[31]}}, v[31:0]} : {32'b0, v[31:0]};
        if (!sg) begin
            u = v;
            do begin
                b   = longint'(u % 64'd128);
                u   = u / 64'd128;
                fin = (u == 0);
                q.push_back({~fin, 7'(b)});
            end while (!fin);
        end else begin
            s = longint'(v);
            do begin
                b   = s & 64'sd127;
                s   = (s - b) / 64'sd128;
                fin = (s == 0 && b < 64) || (s == -1 && b >= 64);
                q.push_back({~fin, 7'(b)});
            end while (!fin);
        end
        return q;
    endfunction

    // Offer one operand and check every emitted byte; bp inserts random stalls.
    task automatic run_op(input string tag, input logic [63:0] v, input bit sg,
                          input bit w64, input byte_q_t exp, input bit bp);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_ready_idle"}, in_ready, 1);
        in_valid  = 1'b1;
        in_value  = v;
        in_signed = sg;
        in_is64   = w64;
        @(negedge clk);
        in_valid  = 1'b0;
        in_value  = {$urandom, $urandom};
        in_signed = 1'($urandom);
        in_is64   = 1'($urandom);
        foreach (exp[i]) begin
            if (bp && ($urandom_range(0, 3) == 0)) begin
                out_ready = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    check({tag, "_stall_byte"}, out_byte, exp[i]);
                    check({tag, "_stall_index"}, out_index, i);
                end
            end
            out_ready = 1'b1;
            check({tag, "_valid"}, out_valid, 1);
            check({tag, "_busy"}, in_ready, 0);
            check({tag, "_byte"}, out_byte, exp[i]);
            check({tag, "_last"}, out_last, (i == exp.size() - 1));
            check({tag, "_index"}, out_index, i);
            @(negedge clk);
        end
        check({tag, "_done_valid"}, out_valid, 0);
        check({tag, "_done_ready"}, in_ready, 1);
    endtask

    initial begin
        byte_q_t     q;
        logic [63:0] v;
        bit          sg, w64;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_value  = '0;
        in_signed = 1'b0;
        in_is64   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_byte", out_byte, 8'h00);
        check("rst_out_index", out_index, 0);
        reset = 1'b0;
        @(negedge clk);

        run_op("u32_624485", 64'd624485, 0, 0, '{8'hE5, 8'h8E, 8'h26}, 0);
        run_op("s64_m123456", -64'sd123456, 1, 1, '{8'hC0, 8'hBB, 8'h78}, 0);
        run_op("s64_64", 64'd64, 1, 1, '{8'hC0, 8'h00}, 0);
        run_op("s64_m64", -64'sd64, 1, 1, '{8'h40}, 0);
        run_op("s64_m1", -64'sd1, 1, 1, '{8'h7F}, 0);
        run_op("u64_0", 64'd0, 0, 1, '{8'h00}, 0);
        q = {};
        repeat (9) q.push_back(8'hFF);
        q.push_back(8'h01);
        run_op("u64_max", '1, 0, 1, q, 0);
        run_op("u32_max", '1, 0, 0, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F}, 0);
        run_op("s32_min", 64'hDEADBEEF_80000000, 1, 0, '{8'h80, 8'h80, 8'h80, 8'h80, 8'h78}, 0);

        // Backpressure: hold byte 0 of uLEB 300 for three cycles.
        in_valid = 1'b1; in_value = 64'd300; in_signed = 1'b0; in_is64 = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) begin
            check("bp_byte", out_byte, 8'hAC);
            check("bp_index", out_index, 0);
            check("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        check("bp_rel_byte0", out_byte, 8'hAC);
        @(negedge clk);
        check("bp_rel_byte1", out_byte, 8'h02);
        check("bp_rel_last", out_last, 1);
        @(negedge clk);

        // Back-to-back: in_valid stays high across two operands.
        in_valid = 1'b1; in_value = 64'd1; in_signed = 1'b0; in_is64 = 1'b0;
        @(negedge clk);
        check("b2b_byte0", out_byte, 8'h01);
        check("b2b_busy", in_ready, 0);
        in_value = 64'd2;
        @(negedge clk);
        check("b2b_gap_valid", out_valid, 0);
        check("b2b_gap_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_byte1", out_byte, 8'h02);
        check("b2b_last1", out_last, 1);
        @(negedge clk);

        // Reset mid-sequence after four bytes, with in_valid asserted alongside.
        in_valid = 1'b1; in_value = '1; in_signed = 1'b0; in_is64 = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_index_before", out_index, 4);
        reset    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_index", out_index, 0);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_no_accept", out_valid, 0);
        run_op("post_rst_5", 64'd5, 0, 1, '{8'h05}, 0);

        // Randomized operands over a spread of magnitudes and modes.
        for (int k = 0; k < 300; k++) begin
            v   = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1) v = ~v;
            sg  = 1'($urandom);
            w64 = 1'($urandom);
            run_op("rand", v, sg, w64, model(v, sg, w64), 1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/leb128_encoder.md
Name: leb128_encoder

Overview:
- Streaming LEB128 encoder: the write-side counterpart to the CPU's LEB128 immediate decoder.
- Takes a 32- or 64-bit integer and emits its unsigned or signed LEB128 byte sequence, one byte per handshake.
- Used by the module/bytecode builder and by test harnesses to generate ROM images (call, const and index immediates) on-chip. Output feeds a byte sink such as the ROM writer.

Parameters:
- WIDTH, 64, maximum operand width in bits. Fixed at 64 for this revision.
- CNT_BITS, 4, width of the byte counter. Must hold ceil(WIDTH/7) = 10.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand offered.
- in_ready  output  1  encoder can accept an operand.
- in_value  input  64  operand. In 32-bit mode only bits [31:0] are used.
- in_signed  input  1  1 = signed LEB128 (sLEB), 0 = unsigned (uLEB).
- in_is64  input  1  1 = 64-bit operand (i64), 0 = 32-bit operand (i32).
- out_valid  output  1  out_byte is valid.
- out_ready  input  1  sink accepts out_byte.
- out_byte  output  8  current encoded byte: {continuation bit, 7 payload bits}.
- out_last  output  1  current byte is the final byte of the sequence (continuation bit = 0).
- out_index  output  4  zero-based position of the current byte in the sequence.

Behaviour:
- Reset (synchronous, active-high) takes effect at the clock edge. After that edge:
  - state = IDLE, in_ready = 1, out_valid = 0, out_last = 0, out_byte = 8'h00, out_index = 0.
- States: IDLE and EMIT.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid && in_ready, latch the operand into a 64-bit shift register `val` and go to EMIT; out_index = 0.
  - Extension on latch, 32-bit mode: uLEB zero-extends bits [31:0]; sLEB sign-extends bit 31.
  - Extension on latch, 64-bit mode: the value is latched unchanged.
- EMIT:
  - in_ready = 0, out_valid = 1.
  - Let rest = val >> 7, arithmetic shift for sLEB and logical shift for uLEB.
  - uLEB done condition: rest == 0.
  - sLEB done condition: (rest == 0 && val[6] == 0) || (rest == all-ones && val[6] == 1).
  - out_byte = {~done, val[6:0]}; out_last = done.
  - On out_valid && out_ready:
    - If done, go to IDLE.
    - Otherwise val <= rest and out_index increments.
- Latency: the first byte is valid on the cycle after input acceptance. Throughput is one byte per cycle while out_ready = 1.
- The next operand can be accepted on the cycle after the last-byte handshake, when in_ready returns high.
- Backpressure: while out_valid && !out_ready, out_byte, out_last and out_index hold stable.
- Inputs are ignored outside IDLE. In 32-bit mode, in_value[63:32] never affects the output.
- Length bounds follow from the done condition:
  - 32-bit mode emits at most 5 bytes.
  - 64-bit mode emits at most 10 bytes; out_index never exceeds 9.
  - The final byte for 64-bit uLEB is at most 8'h01; for 64-bit sLEB it is 8'h00 or 8'h7F.
- Reset mid-sequence: the partial sequence is abandoned; the outputs take their reset values on the next cycle. No byte is emitted after reset is asserted at an edge.
- in_valid together with reset: reset wins and the operand is not accepted.

Test Plan:
- uLEB i32 in_value = 624485 (0x98765) -> bytes E5, 8E, 26; out_last only on 26; out_index 0, 1, 2.
- sLEB i64 in_value = -123456 -> C0, BB, 78. sLEB 64 -> C0, 00. sLEB -64 -> 40. sLEB -1 -> 7F. uLEB 0 -> single byte 00 with out_last = 1.
- Width handling:
  - uLEB i64 0xFFFFFFFFFFFFFFFF -> nine FF bytes then 01 (out_index 9 on last).
  - uLEB i32 same in_value -> FF, FF, FF, FF, 0F (upper word ignored).
  - sLEB i32 in_value = 0xDEADBEEF_80000000 -> 80, 80, 80, 80, 78.
- Backpressure: encode uLEB 300 (AC, 02); hold out_ready = 0 for 3 cycles at byte 0 -> out_byte stays AC, out_index stays 0, in_ready stays 0; release -> AC then 02.
- Back-to-back: in_valid held high with operands 1 then 2 (uLEB) -> 01, 02.
  - in_ready is 0 during EMIT.
  - The second operand is accepted the cycle after the first operand's last-byte handshake.
- Reset mid-operation: start uLEB i64 0xFFFFFFFFFFFFFFFF, assert reset after byte 3 -> next cycle out_valid = 0, in_ready = 1, out_index = 0. A subsequent uLEB 5 encodes as the single byte 05.
